// File: rtl/plic_gateway.sv
// PLIC interrupt gateway: synchronises raw sources, counts edges or follows levels,
// and runs a per-source IDLE/PEND/CLAIM handshake with the PLIC core.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no request outstanding; waiting for level high or cnt != 0
// ST_PEND  | request presented on pend_o; waiting for a claim of this ID
// ST_CLAIM | claimed by the core; waiting for the matching completion
module plic_gateway #(
    parameter int SRC_NUM   = 32,
    parameter int CNT_WIDTH = 4,
    localparam int ID_WIDTH = $clog2(SRC_NUM+1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [SRC_NUM-1:0]  src_i,
    input  logic [SRC_NUM-1:0]  edge_en_i,
    input  logic                claim_i,
    input  logic [ID_WIDTH-1:0] claim_id_i,
    input  logic                complete_i,
    input  logic [ID_WIDTH-1:0] complete_id_i,
    output logic [SRC_NUM-1:0]  pend_o,
    output logic [SRC_NUM-1:0]  ovf_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PEND  = 2'd1;
    localparam logic [1:0] ST_CLAIM = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [SRC_NUM-1:0]   s1_q, s2_q, s3_q;
    logic [2:0]           vld_q;
    logic [SRC_NUM-1:0]   rise;
    logic [SRC_NUM-1:0]   claim_hit, cmpl_hit, dec;
    logic [1:0]           state_q [SRC_NUM];
    logic [1:0]           state_d [SRC_NUM];
    logic [CNT_WIDTH-1:0] cnt_q   [SRC_NUM];
    logic [CNT_WIDTH-1:0] cnt_d   [SRC_NUM];
    logic [SRC_NUM-1:0]   pend_q, pend_d;
    logic [SRC_NUM-1:0]   ovf_q, ovf_d;

    // s3 only holds a real sample three edges after reset; until then a
    // source held high through reset must not look like a fresh rise.
    assign rise = s2_q & ~s3_q & {SRC_NUM{vld_q[2]}};

    always_comb begin
        claim_hit = '0;
        cmpl_hit  = '0;
        for (int k = 0; k < SRC_NUM; k++) begin
            claim_hit[k] = claim_i    && (claim_id_i    == ID_WIDTH'(k + 1));
            cmpl_hit[k]  = complete_i && (complete_id_i == ID_WIDTH'(k + 1));
        end
    end

    always_comb begin
        dec    = '0;
        pend_d = '0;
        ovf_d  = '0;
        for (int k = 0; k < SRC_NUM; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            dec[k]     = claim_hit[k] && (state_q[k] == ST_PEND) && (cnt_q[k] != '0);

            // A rise coinciding with a claim decrement nets to no change.
            if (!edge_en_i[k]) begin
                cnt_d[k] = '0;
            end else if (rise[k] && !dec[k]) begin
                if (cnt_q[k] == CNT_MAX) begin
                    ovf_d[k] = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_ONE;
                end
            end else if (dec[k] && !rise[k]) begin
                cnt_d[k] = cnt_q[k] - CNT_ONE;
            end

            case (state_q[k])
                ST_IDLE: begin
                    if (edge_en_i[k] ? (cnt_q[k] != '0) : s2_q[k]) begin
                        state_d[k] = ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (claim_hit[k]) begin
                        state_d[k] = ST_CLAIM;
                    end
                end
                ST_CLAIM: begin
                    if (cmpl_hit[k]) begin
                        state_d[k] = ST_IDLE;
                    end
                end
                default: state_d[k] = ST_IDLE;
            endcase

            pend_d[k] = (state_d[k] == ST_PEND);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            vld_q  <= '0;
            pend_q <= '0;
            ovf_q  <= '0;
            for (int k = 0; k < SRC_NUM; k++) begin
                state_q[k] <= ST_IDLE;
                cnt_q[k]   <= '0;
            end
        end else begin
            s1_q   <= src_i;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            vld_q  <= {vld_q[1:0], 1'b1};
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            for (int k = 0; k < SRC_NUM; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
        end
    end

    assign pend_o = pend_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_plic_gateway.sv
// Bench for plic_gateway: directed scenarios plus randomized traffic, all checked
// against a history-based reference model of the gateway rules.
module tb_plic_gateway;

    localparam int SRC  = 8;
    localparam int CW   = 2;
    localparam int IDW  = $clog2(SRC + 1);
    localparam int CMAX = (1 << CW) - 1;
    localparam int M_IDLE = 0, M_PEND = 1, M_CLAIM = 2;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic [SRC-1:0] src_i = '0;
    logic [SRC-1:0] edge_en_i = '0;
    logic           claim_i = 1'b0;
    logic [IDW-1:0] claim_id_i = '0;
    logic           complete_i = 1'b0;
    logic [IDW-1:0] complete_id_i = '0;
    logic [SRC-1:0] pend_o, ovf_o;

    plic_gateway #(.SRC_NUM(SRC), .CNT_WIDTH(CW)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .src_i         (src_i),
        .edge_en_i     (edge_en_i),
        .claim_i       (claim_i),
        .claim_id_i    (claim_id_i),
        .complete_i    (complete_i),
        .complete_id_i (complete_id_i),
        .pend_o        (pend_o),
        .ovf_o         (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: sampled input history since reset, plus per-source state/count.
    logic [SRC-1:0] hist[$];
    int             st_m  [SRC];
    int             cnt_m [SRC];
    logic [SRC-1:0] exp_pend = '0;
    logic [SRC-1:0] exp_ovf  = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_edge();
        int n, old;
        logic [SRC-1:0] h2, h3;
        logic lvl, rs, ch, co, dc;
        if (rst_i) begin
            hist.delete();
            for (int k = 0; k < SRC; k++) begin st_m[k] = M_IDLE; cnt_m[k] = 0; end
            exp_pend = '0;
            exp_ovf  = '0;
            return;
        end
        n  = hist.size();
        h2 = (n >= 2) ? hist[n-2] : '0;
        h3 = (n >= 3) ? hist[n-3] : '1;
        for (int k = 0; k < SRC; k++) begin
            lvl = h2[k];
            rs  = h2[k] & ~h3[k];
            ch  = claim_i    && (int'(claim_id_i)    == k + 1);
            co  = complete_i && (int'(complete_id_i) == k + 1);
            old = cnt_m[k];
            exp_ovf[k] = 1'b0;
            if (!edge_en_i[k]) cnt_m[k] = 0;
            else begin
                dc = ch && st_m[k] == M_PEND && old > 0;
                if (rs && !dc && old == CMAX) exp_ovf[k] = 1'b1;
                else cnt_m[k] = old + int'(rs) - int'(dc);
            end
            if (st_m[k] == M_IDLE) begin
                if (edge_en_i[k] ? (old > 0) : lvl) st_m[k] = M_PEND;
            end else if (st_m[k] == M_PEND) begin
                if (ch) st_m[k] = M_CLAIM;
            end else if (co) st_m[k] = M_IDLE;
            exp_pend[k] = (st_m[k] == M_PEND);
        end
        hist.push_back(src_i);
        if (hist.size() > 3) void'(hist.pop_front());
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_edge();
        #1;
        chk("pend_o", 32'(pend_o), 32'(exp_pend));
        chk("ovf_o", 32'(ovf_o), 32'(exp_ovf));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_claim(input int id);
        claim_i = 1'b1; claim_id_i = IDW'(id);
        tick();
        claim_i = 1'b0;
    endtask

    task automatic do_complete(input int id);
        complete_i = 1'b1; complete_id_i = IDW'(id);
        tick();
        complete_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    function automatic logic [IDW-1:0] pick_id(input int which);
        int cand[$];
        for (int k = 0; k < SRC; k++) if (st_m[k] == which) cand.push_back(k + 1);
        if (cand.size() > 0 && $urandom_range(9) < 8)
            return IDW'(cand[$urandom_range(cand.size() - 1)]);
        return IDW'($urandom_range((1 << IDW) - 1));
    endfunction

    initial begin
        int ovf_cnt;
        ticks(2);
        chk("rst_pend", 32'(pend_o), 32'h0);
        chk("rst_ovf", 32'(ovf_o), 32'h0);
        rst_i = 1'b0;
        ticks(4);

        // Level mode latency and claim/complete handshake on source 0.
        src_i[0] = 1'b1;
        tick(); chk("lvl_n0", 32'(pend_o[0]), 32'h0);
        tick(); chk("lvl_n1", 32'(pend_o[0]), 32'h0);
        tick(); chk("lvl_n2", 32'(pend_o[0]), 32'h1);
        do_claim(1);    chk("lvl_claim", 32'(pend_o[0]), 32'h0);
        do_complete(1); chk("lvl_cmpl0", 32'(pend_o[0]), 32'h0);
        tick();         chk("lvl_cmpl1", 32'(pend_o[0]), 32'h1);
        src_i[0] = 1'b0;
        do_claim(1);
        ticks(2);
        do_complete(1);
        ticks(3);       chk("lvl_drop", 32'(pend_o[0]), 32'h0);

        // Ignored strobes on a pending level source.
        src_i[2] = 1'b1;
        ticks(3);       chk("inv_pre", 32'(pend_o[2]), 32'h1);
        do_claim(0);    chk("inv_id0", 32'(pend_o[2]), 32'h1);
        do_claim(SRC + 1); chk("inv_idmax", 32'(pend_o[2]), 32'h1);
        do_complete(3); chk("inv_cmpl", 32'(pend_o[2]), 32'h1);

        // Claim ID 5 and complete ID 3 in the same cycle.
        src_i[4] = 1'b1;
        ticks(3);
        do_claim(3);
        claim_i = 1'b1; claim_id_i = IDW'(5);
        complete_i = 1'b1; complete_id_i = IDW'(3);
        tick();
        claim_i = 1'b0; complete_i = 1'b0;
        chk("dual_p4", 32'(pend_o[4]), 32'h0);
        chk("dual_p2", 32'(pend_o[2]), 32'h0);
        tick();         chk("dual_rep2", 32'(pend_o[2]), 32'h1);

        // Saturating edge counter on source 1.
        src_i = '0; edge_en_i = '0;
        do_reset();
        ticks(4);
        edge_en_i[1] = 1'b1;
        ovf_cnt = 0;
        for (int p = 0; p < 6; p++)
            for (int c = 0; c < 4; c++) begin
                src_i[1] = (p < 5) && (c < 2);
                tick();
                ovf_cnt += int'(ovf_o[1]);
            end
        chk("sat_ovf", 32'(ovf_cnt), 32'd2);
        for (int i = 0; i < 3; i++) begin
            chk("sat_drain", 32'(pend_o[1]), 32'h1);
            do_claim(2);
            do_complete(2);
            tick();
        end
        chk("sat_empty", 32'(pend_o[1]), 32'h0);

        // A rise in the claim cycle leaves the count unchanged.
        src_i[1] = 1'b1; ticks(2); src_i[1] = 1'b0; ticks(3);
        src_i[1] = 1'b1;
        ticks(2);
        do_claim(2);
        src_i[1] = 1'b0;
        do_complete(2);
        tick();         chk("rise_claim", 32'(pend_o[1]), 32'h1);
        do_claim(2);
        do_complete(2);
        tick();         chk("rise_drain", 32'(pend_o[1]), 32'h0);

        // Reset while source 7 is claimed with a count of 2; source 5 held high.
        do_reset();
        ticks(4);
        edge_en_i = 8'hA0;
        for (int p = 0; p < 3; p++) begin
            src_i[7] = 1'b1; ticks(2); src_i[7] = 1'b0; ticks(2);
        end
        ticks(2);
        do_claim(8);    chk("r_claim", 32'(pend_o[7]), 32'h0);
        src_i[5] = 1'b1;
        do_reset();
        chk("r_pend", 32'(pend_o), 32'h0);
        ticks(8);       chk("r_quiet", 32'(pend_o), 32'h0);
        src_i[7] = 1'b1; ticks(2); src_i[7] = 1'b0; ticks(2);
        chk("r_fresh", 32'(pend_o[7]), 32'h1);

        // Randomized traffic against the model.
        edge_en_i = SRC'($urandom);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int k = 0; k < SRC; k++) if ($urandom_range(5) == 0) src_i[k] = ~src_i[k];
            if ($urandom_range(199) == 0) edge_en_i = SRC'($urandom);
            rst_i         = ($urandom_range(699) == 0);
            claim_i       = ($urandom_range(1) == 0);
            claim_id_i    = pick_id(M_PEND);
            complete_i    = ($urandom_range(2) == 0);
            complete_id_i = pick_id(M_CLAIM);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
